// File: rtl/ex_div.sv
// ex_div: multi-cycle restoring divider for DIV/DIVU in the EX stage.
// Produces {remainder, quotient}. ready_o stays high until EX drops start_i.
module ex_div #(
   parameter int unsigned DATA_W = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  signed_div_i,
   input  logic [DATA_W-1:0]     opdata1_i,
   input  logic [DATA_W-1:0]     opdata2_i,
   input  logic                  start_i,
   input  logic                  annul_i,
   output logic [2*DATA_W-1:0]   result_o,
   output logic                  ready_o
);

   localparam int unsigned CNT_W = $clog2(DATA_W + 1);

   typedef enum logic [1:0] {FREE, BYZERO, ON, END} state_e;

   state_e               state_q, state_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic [DATA_W-1:0]    dvd_q, dvd_d;      // dividend magnitude, consumed MSB-first
   logic [DATA_W-1:0]    dvs_q, dvs_d;      // divisor magnitude
   logic [DATA_W-1:0]    rem_q, rem_d;      // partial remainder, always < divisor
   logic [DATA_W-1:0]    quo_q, quo_d;      // quotient bits shifted in LSB-first
   logic                 neg_quo_q, neg_quo_d;
   logic                 neg_rem_q, neg_rem_d;
   logic [2*DATA_W-1:0]  result_q, result_d;
   logic                 ready_q, ready_d;

   logic                 op1_neg;
   logic                 op2_neg;
   logic [DATA_W:0]      rem_shift;
   logic [DATA_W:0]      rem_diff;
   logic [DATA_W-1:0]    quo_fix;
   logic [DATA_W-1:0]    rem_fix;

   assign op1_neg   = signed_div_i & opdata1_i[DATA_W-1];
   assign op2_neg   = signed_div_i & opdata2_i[DATA_W-1];
   // Shifted remainder can exceed DATA_W bits; a borrow in the top bit of
   // the difference means the remainder was smaller than the divisor.
   assign rem_shift = {rem_q, dvd_q[DATA_W-1]};
   assign rem_diff  = rem_shift - {1'b0, dvs_q};
   assign quo_fix   = neg_quo_q ? -quo_q : quo_q;
   assign rem_fix   = neg_rem_q ? -rem_q : rem_q;

   // Next-state and datapath computation for the divider FSM.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      dvd_d     = dvd_q;
      dvs_d     = dvs_q;
      rem_d     = rem_q;
      quo_d     = quo_q;
      neg_quo_d = neg_quo_q;
      neg_rem_d = neg_rem_q;
      result_d  = result_q;
      ready_d   = ready_q;

      case (state_q)
         FREE: begin
            result_d = '0;
            ready_d  = 1'b0;
            cnt_d    = '0;
            if (start_i && !annul_i) begin
               dvd_d     = op1_neg ? -opdata1_i : opdata1_i;
               dvs_d     = op2_neg ? -opdata2_i : opdata2_i;
               rem_d     = '0;
               quo_d     = '0;
               neg_quo_d = op1_neg ^ op2_neg;
               neg_rem_d = op1_neg;
               state_d   = (opdata2_i == '0) ? BYZERO : ON;
            end
         end
         BYZERO: begin
            result_d = '0;
            ready_d  = 1'b1;
            state_d  = END;
         end
         ON: begin
            if (annul_i) begin
               state_d  = FREE;
               cnt_d    = '0;
               result_d = '0;
               ready_d  = 1'b0;
            end else if (cnt_q == CNT_W'(DATA_W)) begin
               result_d = {rem_fix, quo_fix};
               ready_d  = 1'b1;
               state_d  = END;
            end else begin
               if (!rem_diff[DATA_W]) begin
                  rem_d = rem_diff[DATA_W-1:0];
                  quo_d = {quo_q[DATA_W-2:0], 1'b1};
               end else begin
                  rem_d = rem_shift[DATA_W-1:0];
                  quo_d = {quo_q[DATA_W-2:0], 1'b0};
               end
               dvd_d = {dvd_q[DATA_W-2:0], 1'b0};
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         END: begin
            ready_d = 1'b1;
            if (!start_i) begin
               state_d  = FREE;
               ready_d  = 1'b0;
               result_d = '0;
            end
         end
         default: begin
            state_d  = FREE;
            result_d = '0;
            ready_d  = 1'b0;
            cnt_d    = '0;
         end
      endcase
   end

   // State registers; synchronous reset clears control and outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= FREE;
         cnt_q     <= '0;
         result_q  <= '0;
         ready_q   <= 1'b0;
         dvd_q     <= '0;
         dvs_q     <= '0;
         rem_q     <= '0;
         quo_q     <= '0;
         neg_quo_q <= 1'b0;
         neg_rem_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         result_q  <= result_d;
         ready_q   <= ready_d;
         dvd_q     <= dvd_d;
         dvs_q     <= dvs_d;
         rem_q     <= rem_d;
         quo_q     <= quo_d;
         neg_quo_q <= neg_quo_d;
         neg_rem_q <= neg_rem_d;
      end
   end

   assign result_o = result_q;
   assign ready_o  = ready_q;

endmodule

// File: tb/tb_ex_div.sv
// tb_ex_div: directed and randomized checks of ex_div against an
// arithmetic reference model (native / and % on 64-bit integers).
module tb_ex_div;

   logic        clk;
   logic        rst;
   logic        signed_div_i;
   logic [31:0] opdata1_i;
   logic [31:0] opdata2_i;
   logic        start_i;
   logic        annul_i;
   logic [63:0] result_o;
   logic        ready_o;

   int unsigned checks;
   int unsigned failures;

   ex_div #(.DATA_W(32)) dut (
      .clk          (clk),
      .rst          (rst),
      .signed_div_i (signed_div_i),
      .opdata1_i    (opdata1_i),
      .opdata2_i    (opdata2_i),
      .start_i      (start_i),
      .annul_i      (annul_i),
      .result_o     (result_o),
      .ready_o      (ready_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Reference: truncating division, remainder takes the dividend's sign,
   // divide-by-zero yields zero, results truncated to 32 bits.
   function automatic logic [63:0] ref_div(input logic sgn, input logic [31:0] a, input logic [31:0] b);
      longint      sa, sb;
      logic [63:0] q, r;
      if (b == 32'd0) return 64'd0;
      if (sgn) begin
         sa = longint'($signed(a));
         sb = longint'($signed(b));
         q  = sa / sb;
         r  = sa % sb;
         return {r[31:0], q[31:0]};
      end
      return {a % b, a / b};
   endfunction

   // Issue one divide with start held, scramble operands after sampling,
   // then consume the result and release start.
   task automatic do_div(input string tag, input logic sgn, input logic [31:0] a, input logic [31:0] b);
      logic [63:0] exp;
      int          edges;
      int          exp_edges;
      bit          seen;
      exp       = ref_div(sgn, a, b);
      exp_edges = (b == 32'd0) ? 2 : 34;
      @(negedge clk);
      signed_div_i = sgn;
      opdata1_i    = a;
      opdata2_i    = b;
      start_i      = 1'b1;
      edges        = 0;
      seen         = 1'b0;
      while (!seen && edges < 40) begin
         @(posedge clk);
         #1;
         edges++;
         if (ready_o) seen = 1'b1;
         signed_div_i = 1'($urandom);
         opdata1_i    = $urandom;
         opdata2_i    = $urandom;
      end
      check({tag, "_lat"}, 64'(edges), 64'(exp_edges));
      check({tag, "_res"}, result_o, exp);
      @(posedge clk);
      #1;
      check({tag, "_hold_rdy"}, 64'(ready_o), 64'd1);
      check({tag, "_hold_res"}, result_o, exp);
      start_i = 1'b0;
      @(posedge clk);
      #1;
      check({tag, "_rel_rdy"}, 64'(ready_o), 64'd0);
      check({tag, "_rel_res"}, result_o, 64'd0);
   endtask

   initial begin
      checks       = 0;
      failures     = 0;
      rst          = 1'b1;
      signed_div_i = 1'b0;
      opdata1_i    = '0;
      opdata2_i    = '0;
      start_i      = 1'b0;
      annul_i      = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_rdy", 64'(ready_o), 64'd0);
      check("rst_res", result_o, 64'd0);
      rst = 1'b0;

      do_div("divu_7_2", 1'b0, 32'd7, 32'd2);
      check("ref_7_2", ref_div(1'b0, 32'd7, 32'd2), {32'h1, 32'h3});
      do_div("div_m7_2", 1'b1, 32'hFFFFFFF9, 32'h2);
      do_div("div_7_m2", 1'b1, 32'h7, 32'hFFFFFFFE);
      do_div("divu_5_0", 1'b0, 32'd5, 32'd0);
      do_div("divu_max_1", 1'b0, 32'hFFFFFFFF, 32'h1);
      do_div("div_ovf", 1'b1, 32'h80000000, 32'hFFFFFFFF);

      // Annul at cnt==10: the cnt==10 state exists after edge t0+10.
      @(negedge clk);
      signed_div_i = 1'b0;
      opdata1_i    = 32'd100;
      opdata2_i    = 32'd3;
      start_i      = 1'b1;
      repeat (11) @(posedge clk);
      #1;
      annul_i = 1'b1;
      start_i = 1'b0;
      @(posedge clk);
      #1;
      annul_i = 1'b0;
      check("annul_rdy", 64'(ready_o), 64'd0);
      check("annul_res", result_o, 64'd0);
      for (int i = 0; i < 36; i++) begin
         @(posedge clk);
         #1;
         check("annul_quiet", 64'(ready_o), 64'd0);
      end
      do_div("divu_100_3", 1'b0, 32'd100, 32'd3);

      // Reset mid-iteration at cnt==20.
      @(negedge clk);
      signed_div_i = 1'b1;
      opdata1_i    = 32'hDEADBEEF;
      opdata2_i    = 32'd12345;
      start_i      = 1'b1;
      repeat (21) @(posedge clk);
      #1;
      rst     = 1'b1;
      start_i = 1'b0;
      @(posedge clk);
      #1;
      rst = 1'b0;
      check("midrst_rdy", 64'(ready_o), 64'd0);
      check("midrst_res", result_o, 64'd0);
      do_div("divu_9_4", 1'b0, 32'd9, 32'd4);

      // Randomized operands with a bias toward corner values.
      for (int n = 0; n < 40; n++) begin
         logic        sgn;
         logic [31:0] a, b;
         sgn = 1'($urandom);
         a   = $urandom;
         b   = $urandom;
         case ($urandom_range(0, 7))
            0: b = 32'd0;
            1: b = 32'($urandom_range(1, 15));
            2: b = 32'hFFFFFFFF;
            3: a = 32'h80000000;
            4: begin a = 32'($urandom_range(0, 40)); b = 32'($urandom_range(1, 40)); end
            default: ;
         endcase
         do_div("rand", sgn, a, b);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
